// File: rtl/fsab_mem_ingress.sv
// fsab_mem_ingress: sink for the FSAB arbiter output bus in front of the
// memory controller. Whole transactions are buffered: headers go into a
// header FIFO (one entry per credit), write beats into a data FIFO sized for
// every credit carrying a maximum-length write. One fsabo_credit pulse is
// returned per transaction once the controller has fully consumed it.
//
// Ports:
//   clk, Nrst                     clock, asynchronous active-low reset
//   fsabo_valid/mode/did/subdid/addr/len/data/mask
//                                 arbiter output bus (header + write beats)
//   fsabo_credit                  registered one-cycle credit return pulse
//   hdr_valid, hdr_mode/did/subdid/addr/len, hdr_pop
//                                 header stream (head entry, pop handshake)
//   dat_valid, dat_data/mask, dat_pop
//                                 write-data stream (head beat, pop handshake)
//   proto_err                     sticky protocol-error flag
module fsab_mem_ingress #(
  parameter int unsigned FSAB_INITIAL_CREDITS = 4,
  parameter int unsigned FSAB_MAX_BEATS       = 8,
  parameter int unsigned FSAB_REQ_HI          = 0,
  parameter int unsigned FSAB_DID_HI          = 3,
  parameter int unsigned FSAB_ADDR_HI         = 30,
  parameter int unsigned FSAB_LEN_HI          = 3,
  parameter int unsigned FSAB_DATA_HI         = 63,
  parameter int unsigned FSAB_MASK_HI         = 7
) (
  input  logic                    clk,
  input  logic                    Nrst,
  input  logic                    fsabo_valid,
  input  logic [FSAB_REQ_HI:0]    fsabo_mode,
  input  logic [FSAB_DID_HI:0]    fsabo_did,
  input  logic [FSAB_DID_HI:0]    fsabo_subdid,
  input  logic [FSAB_ADDR_HI:0]   fsabo_addr,
  input  logic [FSAB_LEN_HI:0]    fsabo_len,
  input  logic [FSAB_DATA_HI:0]   fsabo_data,
  input  logic [FSAB_MASK_HI:0]   fsabo_mask,
  output logic                    fsabo_credit,
  output logic                    hdr_valid,
  output logic [FSAB_REQ_HI:0]    hdr_mode,
  output logic [FSAB_DID_HI:0]    hdr_did,
  output logic [FSAB_DID_HI:0]    hdr_subdid,
  output logic [FSAB_ADDR_HI:0]   hdr_addr,
  output logic [FSAB_LEN_HI:0]    hdr_len,
  input  logic                    hdr_pop,
  output logic                    dat_valid,
  output logic [FSAB_DATA_HI:0]   dat_data,
  output logic [FSAB_MASK_HI:0]   dat_mask,
  input  logic                    dat_pop,
  output logic                    proto_err
);

  localparam int unsigned LEN_W  = FSAB_LEN_HI + 1;
  localparam int unsigned HDEPTH = FSAB_INITIAL_CREDITS;
  localparam int unsigned DDEPTH = FSAB_INITIAL_CREDITS * FSAB_MAX_BEATS;
  localparam int unsigned HAW    = (HDEPTH > 1) ? $clog2(HDEPTH) : 1;
  localparam int unsigned DAW    = (DDEPTH > 1) ? $clog2(DDEPTH) : 1;

  typedef enum logic {S_IDLE, S_WDATA} state_e;

  // Illegal lengths (0 or above the maximum) are handled as single-beat.
  function automatic logic len_bad(input logic [LEN_W-1:0] l);
    return (l == '0) || (l > LEN_W'(FSAB_MAX_BEATS));
  endfunction

  function automatic logic [LEN_W-1:0] len_eff(input logic [LEN_W-1:0] l);
    return len_bad(l) ? LEN_W'(1) : l;
  endfunction

  // Storage
  logic [FSAB_REQ_HI:0]  hmode_mem [HDEPTH];
  logic [FSAB_DID_HI:0]  hdid_mem  [HDEPTH];
  logic [FSAB_DID_HI:0]  hsub_mem  [HDEPTH];
  logic [FSAB_ADDR_HI:0] haddr_mem [HDEPTH];
  logic [FSAB_LEN_HI:0]  hlen_mem  [HDEPTH];
  logic [FSAB_DATA_HI:0] ddata_mem [DDEPTH];
  logic [FSAB_MASK_HI:0] dmask_mem [DDEPTH];

  state_e           state_q, state_d;
  logic [LEN_W-1:0] beats_q, beats_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             credit_q, credit_d;
  logic             err_q, err_d;
  logic [HAW-1:0]   hwr_q, hwr_d, hrd_q, hrd_d;
  logic [HAW:0]     hcnt_q, hcnt_d;
  logic [DAW-1:0]   dwr_q, dwr_d, drd_q, drd_d;
  logic [DAW:0]     dcnt_q, dcnt_d;

  logic hdr_ne, dat_ne, hdr_pop_ok, dat_pop_ok, hdr_room, dat_room;
  logic hdr_push, dat_push;

  assign hdr_ne     = (hcnt_q != '0);
  assign dat_ne     = (dcnt_q != '0);
  // Headers stay hidden while a popped write still owes data beats.
  assign hdr_valid  = hdr_ne && (rem_q == '0);
  assign dat_valid  = dat_ne && (rem_q != '0);
  assign hdr_pop_ok = hdr_pop && hdr_valid;
  assign dat_pop_ok = dat_pop && dat_valid;
  // A same-cycle pop frees the slot for the push.
  assign hdr_room   = (hcnt_q != (HAW+1)'(HDEPTH)) || hdr_pop_ok;
  assign dat_room   = (dcnt_q != (DAW+1)'(DDEPTH)) || dat_pop_ok;

  assign hdr_mode   = hdr_ne ? hmode_mem[hrd_q] : '0;
  assign hdr_did    = hdr_ne ? hdid_mem[hrd_q]  : '0;
  assign hdr_subdid = hdr_ne ? hsub_mem[hrd_q]  : '0;
  assign hdr_addr   = hdr_ne ? haddr_mem[hrd_q] : '0;
  assign hdr_len    = hdr_ne ? hlen_mem[hrd_q]  : '0;
  assign dat_data   = dat_ne ? ddata_mem[drd_q] : '0;
  assign dat_mask   = dat_ne ? dmask_mem[drd_q] : '0;

  assign fsabo_credit = credit_q;
  assign proto_err    = err_q;

  always_comb begin
    state_d  = state_q;
    beats_d  = beats_q;
    rem_d    = rem_q;
    credit_d = 1'b0;
    err_d    = err_q;
    hdr_push = 1'b0;
    dat_push = 1'b0;

    // Ingress
    if (fsabo_valid) begin
      case (state_q)
        S_IDLE: begin
          if (!hdr_room) begin
            err_d = 1'b1;
          end else begin
            hdr_push = 1'b1;
            if (fsabo_mode[FSAB_REQ_HI]) begin
              if (len_bad(fsabo_len)) err_d = 1'b1;
              if (dat_room) dat_push = 1'b1;
              else          err_d    = 1'b1;
              beats_d = len_eff(fsabo_len) - LEN_W'(1);
              if (len_eff(fsabo_len) != LEN_W'(1)) state_d = S_WDATA;
            end
          end
        end
        S_WDATA: begin
          if (dat_room) dat_push = 1'b1;
          else          err_d    = 1'b1;
          beats_d = beats_q - LEN_W'(1);
          if (beats_q == LEN_W'(1)) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Egress; header and data pops are mutually exclusive via rem_q.
    if (hdr_pop_ok) begin
      if (hmode_mem[hrd_q][FSAB_REQ_HI]) rem_d    = len_eff(hlen_mem[hrd_q]);
      else                               credit_d = 1'b1;
    end
    if (dat_pop_ok) begin
      rem_d = rem_q - LEN_W'(1);
      if (rem_q == LEN_W'(1)) credit_d = 1'b1;
    end

    hwr_d  = hdr_push ? ((hwr_q == HAW'(HDEPTH-1)) ? '0 : hwr_q + HAW'(1)) : hwr_q;
    hrd_d  = hdr_pop_ok ? ((hrd_q == HAW'(HDEPTH-1)) ? '0 : hrd_q + HAW'(1)) : hrd_q;
    hcnt_d = hcnt_q + (HAW+1)'(hdr_push) - (HAW+1)'(hdr_pop_ok);
    dwr_d  = dat_push ? ((dwr_q == DAW'(DDEPTH-1)) ? '0 : dwr_q + DAW'(1)) : dwr_q;
    drd_d  = dat_pop_ok ? ((drd_q == DAW'(DDEPTH-1)) ? '0 : drd_q + DAW'(1)) : drd_q;
    dcnt_d = dcnt_q + (DAW+1)'(dat_push) - (DAW+1)'(dat_pop_ok);
  end

  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      state_q  <= S_IDLE;
      beats_q  <= '0;
      rem_q    <= '0;
      credit_q <= 1'b0;
      err_q    <= 1'b0;
      hwr_q    <= '0;
      hrd_q    <= '0;
      hcnt_q   <= '0;
      dwr_q    <= '0;
      drd_q    <= '0;
      dcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      beats_q  <= beats_d;
      rem_q    <= rem_d;
      credit_q <= credit_d;
      err_q    <= err_d;
      hwr_q    <= hwr_d;
      hrd_q    <= hrd_d;
      hcnt_q   <= hcnt_d;
      dwr_q    <= dwr_d;
      drd_q    <= drd_d;
      dcnt_q   <= dcnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (hdr_push) begin
      hmode_mem[hwr_q] <= fsabo_mode;
      hdid_mem[hwr_q]  <= fsabo_did;
      hsub_mem[hwr_q]  <= fsabo_subdid;
      haddr_mem[hwr_q] <= fsabo_addr;
      hlen_mem[hwr_q]  <= fsabo_len;
    end
    if (dat_push) begin
      ddata_mem[dwr_q] <= fsabo_data;
      dmask_mem[dwr_q] <= fsabo_mask;
    end
  end

endmodule

// File: tb/tb_fsab_mem_ingress.sv
// Randomized + directed bench for fsab_mem_ingress against a queue-based
// transaction model.
module tb_fsab_mem_ingress;
  localparam int CR = 4;
  localparam int MB = 8;

  logic        clk = 1'b0;
  logic        Nrst = 1'b0;
  logic        fsabo_valid = 1'b0;
  logic [0:0]  fsabo_mode = '0;
  logic [3:0]  fsabo_did = '0, fsabo_subdid = '0;
  logic [30:0] fsabo_addr = '0;
  logic [3:0]  fsabo_len = '0;
  logic [63:0] fsabo_data = '0;
  logic [7:0]  fsabo_mask = '0;
  logic        fsabo_credit;
  logic        hdr_valid;
  logic [0:0]  hdr_mode;
  logic [3:0]  hdr_did, hdr_subdid;
  logic [30:0] hdr_addr;
  logic [3:0]  hdr_len;
  logic        hdr_pop = 1'b0;
  logic        dat_valid;
  logic [63:0] dat_data;
  logic [7:0]  dat_mask;
  logic        dat_pop = 1'b0;
  logic        proto_err;

  fsab_mem_ingress #(.FSAB_INITIAL_CREDITS(CR), .FSAB_MAX_BEATS(MB)) dut (
    .clk(clk), .Nrst(Nrst),
    .fsabo_valid(fsabo_valid), .fsabo_mode(fsabo_mode), .fsabo_did(fsabo_did),
    .fsabo_subdid(fsabo_subdid), .fsabo_addr(fsabo_addr), .fsabo_len(fsabo_len),
    .fsabo_data(fsabo_data), .fsabo_mask(fsabo_mask), .fsabo_credit(fsabo_credit),
    .hdr_valid(hdr_valid), .hdr_mode(hdr_mode), .hdr_did(hdr_did),
    .hdr_subdid(hdr_subdid), .hdr_addr(hdr_addr), .hdr_len(hdr_len),
    .hdr_pop(hdr_pop), .dat_valid(dat_valid), .dat_data(dat_data),
    .dat_mask(dat_mask), .dat_pop(dat_pop), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic [3:0]  did;
    logic [3:0]  sub;
    logic [30:0] addr;
    logic [3:0]  len;
  } hdr_t;
  typedef struct {
    logic [63:0] d;
    logic [7:0]  m;
  } beat_t;

  // Model state: contents visible after the most recent clock edge.
  hdr_t  hq[$];
  beat_t dq[$];
  int    rem = 0;
  int    wr_left = 0;
  bit    m_err = 1'b0;
  bit    m_credit = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clampl(input int l);
    return (l == 0 || l > MB) ? 1 : l;
  endfunction

  task automatic compare_outputs();
    bit hv, dv;
    hdr_t h;
    beat_t b;
    hv = (hq.size() != 0) && (rem == 0);
    dv = (dq.size() != 0) && (rem != 0);
    chk("credit", 64'(fsabo_credit), 64'(m_credit));
    chk("hdr_valid", 64'(hdr_valid), 64'(hv));
    chk("dat_valid", 64'(dat_valid), 64'(dv));
    chk("proto_err", 64'(proto_err), 64'(m_err));
    if (hv) begin
      h = hq[0];
      chk("hdr_mode", 64'(hdr_mode), 64'(h.mode));
      chk("hdr_did", 64'(hdr_did), 64'(h.did));
      chk("hdr_subdid", 64'(hdr_subdid), 64'(h.sub));
      chk("hdr_addr", 64'(hdr_addr), 64'(h.addr));
      chk("hdr_len", 64'(hdr_len), 64'(h.len));
    end
    if (dv) begin
      b = dq[0];
      chk("dat_data", dat_data, b.d);
      chk("dat_mask", 64'(dat_mask), 64'(b.m));
    end
  endtask

  task automatic push_beat(input logic [63:0] d, input logic [7:0] m);
    beat_t b;
    b.d = d;
    b.m = m;
    if (dq.size() == CR*MB) m_err = 1'b1;
    else dq.push_back(b);
  endtask

  // One clock: check the state left by the previous edge, drive inputs,
  // then advance the model to what the next edge should produce.
  task automatic cycle(input bit v, input bit mode, input logic [3:0] did,
                       input logic [3:0] sub, input logic [30:0] addr,
                       input logic [3:0] len, input logic [63:0] d,
                       input logic [7:0] m, input bit hp, input bit dp);
    bit hv, dv;
    hdr_t h;
    beat_t b;
    @(negedge clk);
    compare_outputs();
    fsabo_valid = v; fsabo_mode = mode; fsabo_did = did; fsabo_subdid = sub;
    fsabo_addr = addr; fsabo_len = len; fsabo_data = d; fsabo_mask = m;
    hdr_pop = hp; dat_pop = dp;

    hv = (hq.size() != 0) && (rem == 0);
    dv = (dq.size() != 0) && (rem != 0);
    m_credit = 1'b0;
    if (hp && hv) begin
      h = hq.pop_front();
      if (h.mode) rem = clampl(int'(h.len));
      else m_credit = 1'b1;
    end
    if (dp && dv) begin
      b = dq.pop_front();
      rem--;
      if (rem == 0) m_credit = 1'b1;
    end
    if (v) begin
      if (wr_left == 0) begin
        if (hq.size() == CR) m_err = 1'b1;
        else begin
          h.mode = mode; h.did = did; h.sub = sub; h.addr = addr; h.len = len;
          hq.push_back(h);
          if (mode) begin
            if (len == 4'd0 || int'(len) > MB) m_err = 1'b1;
            push_beat(d, m);
            wr_left = clampl(int'(len)) - 1;
          end
        end
      end else begin
        push_beat(d, m);
        wr_left--;
      end
    end
  endtask

  task automatic idle(input int n, input bit hp, input bit dp);
    for (int i = 0; i < n; i++)
      cycle(1'b0, 1'b0, '0, '0, '0, '0, '0, '0, hp, dp);
  endtask

  task automatic rd(input logic [3:0] did, input logic [30:0] addr, input bit hp);
    cycle(1'b1, 1'b0, did, 4'd0, addr, 4'd1, '0, '0, hp, 1'b0);
  endtask

  task automatic check_reset_zero(input string tag);
    chk({tag, "_credit"}, 64'(fsabo_credit), 64'd0);
    chk({tag, "_hdr_valid"}, 64'(hdr_valid), 64'd0);
    chk({tag, "_dat_valid"}, 64'(dat_valid), 64'd0);
    chk({tag, "_proto_err"}, 64'(proto_err), 64'd0);
    chk({tag, "_hdr_fields"}, 64'({hdr_mode, hdr_did, hdr_subdid, hdr_len}), 64'd0);
    chk({tag, "_hdr_addr"}, 64'(hdr_addr), 64'd0);
    chk({tag, "_dat_data"}, dat_data, 64'd0);
    chk({tag, "_dat_mask"}, 64'(dat_mask), 64'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    fsabo_valid = 1'b0; hdr_pop = 1'b0; dat_pop = 1'b0;
    #2 Nrst = 1'b0;
    #1 check_reset_zero(tag);
    hq.delete(); dq.delete();
    rem = 0; wr_left = 0; m_err = 1'b0; m_credit = 1'b0;
    @(negedge clk);
    Nrst = 1'b1;
  endtask

  task automatic random_phase(input int n, input bit illegal);
    int credits, wl;
    bit v, mode;
    logic [3:0] len;
    credits = CR;
    wl = 0;
    for (int i = 0; i < n; i++) begin
      v = 1'b0;
      mode = 1'($urandom_range(0, 1));
      len = 4'($urandom_range(1, MB));
      if (wl > 0) begin
        if ($urandom_range(0, 9) < 7) begin v = 1'b1; wl--; end
      end else if (credits > 0 && $urandom_range(0, 9) < 5) begin
        v = 1'b1;
        if (illegal && mode && $urandom_range(0, 3) == 0)
          len = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(9, 15));
        credits--;
        wl = mode ? clampl(int'(len)) - 1 : 0;
      end else if (illegal && $urandom_range(0, 19) == 0) begin
        // Credit-ignoring read: may hit a full header FIFO.
        v = 1'b1;
        mode = 1'b0;
      end
      cycle(v, mode, 4'($urandom), 4'($urandom), 31'($urandom), len,
            {$urandom, $urandom}, 8'($urandom),
            1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 6));
      if (m_credit && credits < CR) credits++;
    end
  endtask

  initial begin
    #23 check_reset_zero("por");
    @(negedge clk);
    Nrst = 1'b1;

    // Single read
    rd(4'd2, 31'h100, 1'b0);
    idle(1, 1'b0, 1'b0);
    idle(1, 1'b1, 1'b0);
    idle(3, 1'b0, 1'b1);

    // Write len 4 with a gap between beats 2 and 3; pops while hidden ignored
    cycle(1'b1, 1'b1, 4'd5, 4'd1, 31'h200, 4'd4, 64'hA0, 8'hFF, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 4'd0, 4'd0, 31'h0, 4'd0, 64'hA1, 8'h0F, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 4'd0, 4'd0, 31'h0, 4'd0, 64'hA2, 8'hF0, 1'b0, 1'b0);
    idle(1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 4'd9, 4'd9, 31'h999, 4'd9, 64'hA3, 8'h3C, 1'b0, 1'b0);
    idle(2, 1'b0, 1'b1);
    idle(1, 1'b1, 1'b0);
    idle(6, 1'b0, 1'b1);

    // Full header FIFO with simultaneous push and pop
    for (int i = 0; i < CR; i++) rd(4'(i), 31'(16'h40 + i), 1'b0);
    idle(1, 1'b0, 1'b0);
    rd(4'd7, 31'h50, 1'b1);
    idle(6, 1'b1, 1'b0);

    // Overflow: fifth header dropped
    for (int i = 0; i < CR + 1; i++) rd(4'(i + 3), 31'(16'h60 + i), 1'b0);
    idle(1, 1'b0, 1'b0);
    idle(6, 1'b1, 1'b0);

    // Write with len 0
    do_reset("rst1");
    cycle(1'b1, 1'b1, 4'd1, 4'd2, 31'h300, 4'd0, 64'h55, 8'h01, 1'b0, 1'b0);
    idle(1, 1'b0, 1'b0);
    idle(1, 1'b1, 1'b0);
    idle(3, 1'b0, 1'b1);

    // Reset mid-write, then a normal read
    do_reset("rst2");
    cycle(1'b1, 1'b1, 4'd3, 4'd3, 31'h400, 4'd4, 64'hB0, 8'hFF, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 4'd0, 4'd0, 31'h0, 4'd0, 64'hB1, 8'hFF, 1'b0, 1'b0);
    do_reset("rst_mid");
    rd(4'd6, 31'h500, 1'b0);
    idle(1, 1'b1, 1'b0);
    idle(3, 1'b0, 1'b0);

    // Randomized traffic
    do_reset("rst3");
    random_phase(400, 1'b0);
    idle(40, 1'b1, 1'b1);
    do_reset("rst4");
    random_phase(400, 1'b1);
    idle(40, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
